uart_rx_frame: RTL and testbench

//   UART receive path, the counterpart of the UART-Tx chain. Synchronises the serial

---
 rtl/uart_rx_frame.sv | 137 +++++++++++++
 tb/tb_uart_rx_frame.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receiver: 2-flop line synchroniser, start-bit validation and mid-bit sampling
// driven by an oversampling tick. Frame format: LSB-first data, optional parity, one stop bit.
module uart_rx_frame #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter bit          PARITY_EN  = 1'b1,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_baud_tick,
   input  logic                 i_rx_in,
   output logic [DATA_BITS-1:0] o_data_out,
   output logic                 o_done_flag,
   output logic                 o_parity_err,
   output logic                 o_stop_err,
   output logic                 o_busy
);

   localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS);
   localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               r_state;
   logic                 r_sync1;
   logic                 r_rx_s;
   logic [TICK_W-1:0]    r_tick_cnt;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity_bit;
   logic                 w_parity_err;

   // Line idles high, so the synchroniser resets to 1 to avoid a false start.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= i_rx_in;
         r_rx_s  <= r_sync1;
      end
   end

   assign w_parity_err = PARITY_EN & ((^{r_shift, r_parity_bit}) ^ PARITY_ODD);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_tick_cnt   <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_parity_bit <= 1'b0;
         o_data_out   <= '0;
         o_done_flag  <= 1'b0;
         o_parity_err <= 1'b0;
         o_stop_err   <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         o_done_flag <= 1'b0;
         if (i_baud_tick) begin
            case (r_state)
               S_IDLE: begin
                  if (!r_rx_s) begin
                     r_state    <= S_START;
                     r_tick_cnt <= '0;
                     o_busy     <= 1'b1;
                  end
               end
               S_START: begin
                  if (r_tick_cnt == HALF_LAST) begin
                     r_tick_cnt <= '0;
                     r_bit_cnt  <= '0;
                     if (!r_rx_s) begin
                        r_state <= S_DATA;
                     end else begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                  end
               end
               S_DATA: begin
                  if (r_tick_cnt == FULL_LAST) begin
                     r_tick_cnt <= '0;
                     r_shift    <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                     r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
                     if (r_bit_cnt == BIT_LAST) begin
                        r_state <= PARITY_EN ? S_PARITY : S_STOP;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                  end
               end
               S_PARITY: begin
                  if (r_tick_cnt == FULL_LAST) begin
                     r_tick_cnt   <= '0;
                     r_parity_bit <= r_rx_s;
                     r_state      <= S_STOP;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                  end
               end
               S_STOP: begin
                  // Publish the whole frame at once so outputs never change mid-frame.
                  if (r_tick_cnt == FULL_LAST) begin
                     r_tick_cnt   <= '0;
                     o_data_out   <= r_shift;
                     o_parity_err <= w_parity_err;
                     o_stop_err   <= ~r_rx_s;
                     o_done_flag  <= 1'b1;
                     r_state      <= S_IDLE;
                     o_busy       <= 1'b0;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  o_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed and random frames; expected results are queued by the
// driver and compared by an independent monitor on every DoneFlag pulse.
module tb_uart_rx_frame;

   localparam int OS       = 16;
   localparam int TICK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud_tick = 1'b0;
   logic       rx_in;
   logic [7:0] data_out;
   logic       done_flag;
   logic       parity_err;
   logic       stop_err;
   logic       busy;

   uart_rx_frame #(
      .OVERSAMPLE(OS),
      .DATA_BITS (8),
      .PARITY_EN (1'b1),
      .PARITY_ODD(1'b0)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_baud_tick (baud_tick),
      .i_rx_in     (rx_in),
      .o_data_out  (data_out),
      .o_done_flag (done_flag),
      .o_parity_err(parity_err),
      .o_stop_err  (stop_err),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   int div_cnt = 0;
   always @(negedge clk) begin
      div_cnt   = (div_cnt + 1) % TICK_DIV;
      baud_tick = (div_cnt == 0);
   end

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       serr;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endfunction

   // Monitor: every DoneFlag pulse must match the oldest outstanding frame.
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done_flag) begin
         check("done_single_cycle", 32'(prev_done), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("data_out", 32'(data_out), 32'(e.data));
            check("parity_err", 32'(parity_err), 32'(e.perr));
            check("stop_err", 32'(stop_err), 32'(e.serr));
         end
      end
      prev_done = done_flag;
   end

   task automatic wait_tick();
      do @(posedge clk); while (!baud_tick);
   endtask

   task automatic drive_bit(input logic v, input int n);
      #1 rx_in = v;
      repeat (n) wait_tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"}, 32'(data_out), 32'd0);
      check({tag, "_done"}, 32'(done_flag), 32'd0);
      check({tag, "_perr"}, 32'(parity_err), 32'd0);
      check({tag, "_serr"}, 32'(stop_err), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Even parity: the correct parity bit makes the total count of ones even.
   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_bit,
                             input int gap, input int abort_bit = -1);
      logic par;
      par = (^d) ^ bad_par;
      if (abort_bit < 0) exp_q.push_back('{d, bad_par, ~stop_bit});
      drive_bit(1'b0, OS);
      for (int i = 0; i < 8; i++) begin
         if (i == 4 || i == abort_bit) begin
            drive_bit(d[i], OS / 2);
            #2 check("busy_mid_frame", 32'(busy), 32'd1);
            if (i == abort_bit) begin
               rst = 1'b1;
               repeat (2) @(posedge clk);
               #2 check_reset_outputs("mid_reset");
               rst = 1'b0;
               drive_bit(1'b1, 20);
               return;
            end
            drive_bit(d[i], OS / 2);
         end else begin
            drive_bit(d[i], OS);
         end
      end
      drive_bit(par, OS);
      drive_bit(stop_bit, OS);
      if (gap > 0) drive_bit(1'b1, gap);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] s_data;
      logic       s_perr;
      logic       s_serr;
      rst   = 1'b1;
      rx_in = 1'b1;
      repeat (3) @(posedge clk);
      #2 check_reset_outputs("reset");
      rst = 1'b0;
      drive_bit(1'b1, 10);

      send_frame(8'h55, 1'b0, 1'b1, 4);
      send_frame(8'hA3, 1'b1, 1'b1, 4);

      // Short low pulse on the line must be rejected as a glitch.
      s_data = data_out;
      s_perr = parity_err;
      s_serr = stop_err;
      drive_bit(1'b0, 4);
      drive_bit(1'b1, 16);
      #2;
      check("glitch_busy", 32'(busy), 32'd0);
      check("glitch_data_hold", 32'(data_out), 32'(s_data));
      check("glitch_perr_hold", 32'(parity_err), 32'(s_perr));
      check("glitch_serr_hold", 32'(stop_err), 32'(s_serr));

      send_frame(8'h0F, 1'b0, 1'b0, 20);
      send_frame(8'h3C, 1'b0, 1'b1, 4);

      send_frame(8'hFF, 1'b0, 1'b1, 0, 4);
      send_frame(8'h81, 1'b0, 1'b1, 4);

      send_frame(8'h12, 1'b0, 1'b1, 0);
      send_frame(8'h34, 1'b0, 1'b1, 4);

      for (int k = 0; k < 30; k++) begin
         logic [7:0] d;
         bit         bad;
         bit         stp;
         d   = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 3) == 0);
         stp = ($urandom_range(0, 5) != 0);
         send_frame(d, bad, stp, stp ? int'($urandom_range(0, 5)) : 20);
      end

      repeat (40) wait_tick();
      #2;
      check("all_frames_seen", 32'(exp_q.size()), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
